regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the decode stage; successor to the single-write, two-read file.
//  N combinational read ports with same-cycle write-to-read bypass, two write ports (WB, late-load), x0 hardwired zero.
//  Synchronous clear sequencer zeroes the array after reset; writes on posedge only (no negedge writes).
// PARAMETERS
//  XLEN     64  data width in bits
//  DEPTH    32  number of architectural registers (power of 2, >=2); AW = $clog2(DEPTH)
//  NUM_RD   2   number of read ports (1..4)
// PORTS
//  clk       in   1            core clock, all state on posedge
//  rst_n     in   1            synchronous active-low reset
//  rd_addr   in   NUM_RD*AW    packed read addresses, port i at [i*AW +: AW]
//  rd_data   out  NUM_RD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
//  we0       in   1            write enable, port 0 (writeback)
//  waddr0    in   AW           write address, port 0
//  wdata0    in   XLEN         write data, port 0
//  we1       in   1            write enable, port 1 (late load return)
//  waddr1    in   AW           write address, port 1
//  wdata1    in   XLEN         write data, port 1
//  busy      out  1            high while clear sequence runs; stall decode
//  wr_drop   out  1            1-cycle pulse: an enabled write was discarded
// BEHAVIOUR
//  - Reset: sampled on posedge; while rst_n=0: state<=RST, busy=1, wr_drop=0, clear counter<=1, rd_data=0.
//  - FSM RST -(rst_n=1)-> CLEAR -(counter==DEPTH-1 written)-> READY; rst_n=0 from any state -> RST.
//  - CLEAR: one register zeroed per cycle, addresses 1..DEPTH-1; takes DEPTH-1 cycles; busy=1; all rd_data=0.
//  - Reset mid-CLEAR restarts counter at 1; no partial completion credit.
//  - READY: busy=0; write port k commits wdata_k to reg[waddr_k] at posedge when we_k=1 and waddr_k!=0.
//  - Write to x0: discarded, wr_drop=1 next cycle; reg[0] always reads 0 (no storage).
//  - Write during RST/CLEAR: discarded, wr_drop=1 next cycle (RST: wr_drop held 0).
//  - Same address on both ports, same cycle: port 1 wins; port 0 discarded, wr_drop=1.
//  - Reads: combinational, 0-cycle latency. Bypass priority per port: addr==0 -> 0; match waddr1&we1 -> wdata1;
//    match waddr0&we0 -> wdata0; else array. Bypass active only in READY.
//  - Widths: no arithmetic; address compare is full AW bits; DEPTH not power of 2 is illegal (elab $error).
// CONFIGURATION
//  REGFILE_DEBUG_EN defined: adds ports dbg_addr in AW, dbg_data out XLEN (combinational, no bypass),
//    last_wr_addr out AW / last_wr_data out XLEN (registered, last committed write, port 1 if dual; reset 0),
//    and a $display per committed write.
//  Not defined: those ports and displays do not exist; no file I/O of any kind in either mode.
// STRUCTURE
//  regfile_pkg: typedef enum {RST, CLEAR, READY} rf_state_t; localparam helpers for AW; X0_ADDR constant.
//  Sub-module regfile_bypass_mux: one read port's priority select (addr, two write ports, array word) -> data;
//    instantiated NUM_RD times via generate.
//  Array: DEPTH-1 x XLEN flops (index 0 not stored).
// TESTING
//  1 rst_n=0 3 cycles then 1 -> busy=1 for exactly 31 cycles (DEPTH=32), every rd_data=0, then busy=0.
//  2 READY, we0=1 waddr0=5 wdata0=0x1234, rd_addr[0]=5 same cycle -> rd_data[0]=0x1234 (bypass); next cycle from array.
//  3 we0=1,we1=1 both waddr=7, wdata0=0xA, wdata1=0xB -> reg7=0xB, wr_drop=1 next cycle.
//  4 we1=1 waddr1=0 wdata1=0xFFFF -> wr_drop=1; read x0 on all ports -> 0.
//  5 rst_n=0 at clear counter=10, release -> busy restarts, lasts 31 cycles; write issued while busy -> wr_drop=1, reg unchanged.
//  6 NUM_RD=4, XLEN=32, DEPTH=16: random writes vs. reference model 1000 cycles -> zero mismatches.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared types and helpers for the multi-port register file.
//             - rf_state_t : lifecycle state (RST -> CLEAR -> READY)
//             - X0_ADDR    : architectural address of the hardwired-zero reg
//             - rf_aw()    : address width for a given register count
//             - rf_is_pow2(): legality check for the register count
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      CLEAR = 2'd1,
      READY = 2'd2
   } rf_state_t;

   localparam int X0_ADDR = 0;

   // Address width; a 1-register file still needs one address bit.
   function automatic int rf_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit rf_is_pow2(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_bypass_mux.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_bypass_mux
//  Purpose  : Priority select for one combinational read port.
//             Order: x0 -> 0, write port 1 hit, write port 0 hit, array word.
//             When enable is low (file not ready) the port reads 0.
//  Ports    : enable        in  1     bypass/read enable (file READY)
//             rd_addr       in  AW    read address
//             we0/we1       in  1     write enables of the two write ports
//             waddr0/waddr1 in  AW    write addresses
//             wdata0/wdata1 in  XLEN  write data
//             arr_word      in  XLEN  stored word at rd_addr
//             rd_data       out XLEN  selected read data
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_bypass_mux
   import regfile_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int AW   = 5
)(
   input  logic            enable,
   input  logic [AW-1:0]   rd_addr,
   input  logic            we0,
   input  logic [AW-1:0]   waddr0,
   input  logic [XLEN-1:0] wdata0,
   input  logic            we1,
   input  logic [AW-1:0]   waddr1,
   input  logic [XLEN-1:0] wdata1,
   input  logic [XLEN-1:0] arr_word,
   output logic [XLEN-1:0] rd_data
);

   localparam logic [AW-1:0] C_X0 = AW'(X0_ADDR);

   // Port 1 is checked before port 0 so the bypassed value matches what the
   // array will hold when both ports target the same register.
   always_comb begin
      rd_data = arr_word;
      if (!enable || (rd_addr == C_X0)) begin
         rd_data = '0;
      end else if (we1 && (waddr1 == rd_addr)) begin
         rd_data = wdata1;
      end else if (we0 && (waddr0 == rd_addr)) begin
         rd_data = wdata0;
      end
   end

endmodule : regfile_bypass_mux
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port integer register file for the decode stage.
//             NUM_RD combinational read ports with same-cycle write bypass,
//             two write ports (0 = writeback, 1 = late load), x0 reads zero.
//             After reset a sequencer zeroes registers 1..DEPTH-1, one per
//             cycle, while busy is high.
//  Ports    : clk          in  1            core clock
//             rst_n        in  1            synchronous active-low reset
//             rd_addr      in  NUM_RD*AW    packed read addresses
//             rd_data      out NUM_RD*XLEN  packed read data
//             we0/waddr0/wdata0 in          write port 0
//             we1/waddr1/wdata1 in          write port 1 (wins on collision)
//             busy         out 1            clear sequence in progress
//             wr_drop      out 1            pulse: an enabled write was dropped
//  Option   : REGFILE_DEBUG_EN adds dbg_addr/dbg_data (raw array peek),
//             last_wr_addr/last_wr_data (last committed write) and a
//             $display per committed write.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int XLEN   = 64,
   parameter  int DEPTH  = 32,
   parameter  int NUM_RD = 2,
   localparam int AW     = rf_aw(DEPTH)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   input  logic                   we0,
   input  logic [AW-1:0]          waddr0,
   input  logic [XLEN-1:0]        wdata0,
   input  logic                   we1,
   input  logic [AW-1:0]          waddr1,
   input  logic [XLEN-1:0]        wdata1,
   output logic                   busy,
   output logic                   wr_drop
`ifdef REGFILE_DEBUG_EN
   ,
   input  logic [AW-1:0]          dbg_addr,
   output logic [XLEN-1:0]        dbg_data,
   output logic [AW-1:0]          last_wr_addr,
   output logic [XLEN-1:0]        last_wr_data
`endif
);

   localparam logic [AW-1:0] C_X0   = AW'(X0_ADDR);
   localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

   // ---------------------------------------------------------------------
   // Elaboration-time legality checks
   // ---------------------------------------------------------------------
   generate
      if (!rf_is_pow2(DEPTH)) begin : g_bad_depth
         $error("regfile_mp: DEPTH (%0d) must be a power of 2 and >= 2", DEPTH);
      end
      if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
         $error("regfile_mp: NUM_RD (%0d) must be in 1..4", NUM_RD);
      end
   endgenerate

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   rf_state_t       r_state;
   rf_state_t       w_state_nxt;
   logic [AW-1:0]   r_clr_cnt;
   logic            r_wr_drop;
   logic [XLEN-1:0] r_regs [1:DEPTH-1];   // x0 has no storage

   logic w_ready;
   logic w_clearing;
   logic w_clr_done;
   logic w_commit0;
   logic w_commit1;
   logic w_drop_nxt;

   assign w_ready    = (r_state == READY);
   assign w_clearing = (r_state == CLEAR);
   assign w_clr_done = w_clearing && (r_clr_cnt == C_LAST);

   // Port 1 always commits if legal; port 0 yields on an address collision.
   // A reset sampled on the same edge suppresses both.
   assign w_commit1 = rst_n && w_ready && we1 && (waddr1 != C_X0);
   assign w_commit0 = rst_n && w_ready && we0 && (waddr0 != C_X0) &&
                      !(we1 && (waddr1 == waddr0));

   // Any enabled write that does not commit is reported, except in RST
   // where wr_drop stays low.
   assign w_drop_nxt = (w_clearing && (we0 || we1)) ||
                       (w_ready && ((we0 && !w_commit0) || (we1 && !w_commit1)));

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= RST;
         r_clr_cnt <= AW'(1);
         r_wr_drop <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_wr_drop <= w_drop_nxt;
         if (w_clearing && !w_clr_done) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state (reset is handled in the register process)
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RST:     w_state_nxt = CLEAR;
         CLEAR:   if (w_clr_done) w_state_nxt = READY;
         READY:   w_state_nxt = READY;
         default: w_state_nxt = RST;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      busy    = !w_ready;
      wr_drop = r_wr_drop;
   end

   // ---------------------------------------------------------------------
   // Storage array. Clear writes and functional writes are mutually
   // exclusive by state, and the two functional ports never hit the same
   // register in one cycle, so write order inside this block is irrelevant.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (w_clearing) begin
            r_regs[r_clr_cnt] <= '0;
         end
         if (w_commit0) begin
            r_regs[waddr0] <= wdata0;
         end
         if (w_commit1) begin
            r_regs[waddr1] <= wdata1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [AW-1:0]   w_addr;
         logic [XLEN-1:0] w_word;

         assign w_addr = rd_addr[gi*AW +: AW];
         assign w_word = (w_addr == C_X0) ? '0 : r_regs[w_addr];

         regfile_bypass_mux #(
            .XLEN (XLEN),
            .AW   (AW)
         ) u_mux (
            .enable   (w_ready),
            .rd_addr  (w_addr),
            .we0      (we0),
            .waddr0   (waddr0),
            .wdata0   (wdata0),
            .we1      (we1),
            .waddr1   (waddr1),
            .wdata1   (wdata1),
            .arr_word (w_word),
            .rd_data  (rd_data[gi*XLEN +: XLEN])
         );
      end
   endgenerate

`ifdef REGFILE_DEBUG_EN
   // ---------------------------------------------------------------------
   // Debug visibility
   // ---------------------------------------------------------------------
   logic [AW-1:0]   r_last_addr;
   logic [XLEN-1:0] r_last_data;

   assign dbg_data     = (dbg_addr == C_X0) ? '0 : r_regs[dbg_addr];
   assign last_wr_addr = r_last_addr;
   assign last_wr_data = r_last_data;

   // Port 1 is recorded when both ports commit in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_addr <= '0;
         r_last_data <= '0;
      end else if (w_commit1) begin
         r_last_addr <= waddr1;
         r_last_data <= wdata1;
      end else if (w_commit0) begin
         r_last_addr <= waddr0;
         r_last_data <= wdata0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_commit0) begin
         $display("regfile_mp: wr0 x%0d <= 0x%h", waddr0, wdata0);
      end
      if (w_commit1) begin
         $display("regfile_mp: wr1 x%0d <= 0x%h", waddr1, wdata1);
      end
   end
`endif

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp. Instance A uses the default
//             geometry (XLEN=64, DEPTH=32, NUM_RD=2); instance B uses
//             XLEN=32, DEPTH=16, NUM_RD=4 for randomized traffic against a
//             register-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

   localparam int A_XLEN = 64, A_DEPTH = 32, A_NRD = 2, A_AW = 5;
   localparam int B_XLEN = 32, B_DEPTH = 16, B_NRD = 4, B_AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A
   logic                     a_rst_n;
   logic [A_NRD*A_AW-1:0]    a_rd_addr;
   logic [A_NRD*A_XLEN-1:0]  a_rd_data;
   logic                     a_we0, a_we1;
   logic [A_AW-1:0]          a_waddr0, a_waddr1;
   logic [A_XLEN-1:0]        a_wdata0, a_wdata1;
   logic                     a_busy, a_wr_drop;

   // Instance B
   logic                     b_rst_n;
   logic [B_NRD*B_AW-1:0]    b_rd_addr;
   logic [B_NRD*B_XLEN-1:0]  b_rd_data;
   logic                     b_we0, b_we1;
   logic [B_AW-1:0]          b_waddr0, b_waddr1;
   logic [B_XLEN-1:0]        b_wdata0, b_wdata1;
   logic                     b_busy, b_wr_drop;

   int checks = 0;
   int errors = 0;

   logic [B_XLEN-1:0] mb [B_DEPTH];   // reference contents of instance B

   regfile_mp #(.XLEN(A_XLEN), .DEPTH(A_DEPTH), .NUM_RD(A_NRD)) u_dut_a (
      .clk     (clk),
      .rst_n   (a_rst_n),
      .rd_addr (a_rd_addr),
      .rd_data (a_rd_data),
      .we0     (a_we0),
      .waddr0  (a_waddr0),
      .wdata0  (a_wdata0),
      .we1     (a_we1),
      .waddr1  (a_waddr1),
      .wdata1  (a_wdata1),
      .busy    (a_busy),
      .wr_drop (a_wr_drop)
   );

   regfile_mp #(.XLEN(B_XLEN), .DEPTH(B_DEPTH), .NUM_RD(B_NRD)) u_dut_b (
      .clk     (clk),
      .rst_n   (b_rst_n),
      .rd_addr (b_rd_addr),
      .rd_data (b_rd_data),
      .we0     (b_we0),
      .waddr0  (b_waddr0),
      .wdata0  (b_wdata0),
      .we1     (b_we1),
      .waddr1  (b_waddr1),
      .wdata1  (b_wdata1),
      .busy    (b_busy),
      .wr_drop (b_wr_drop)
   );

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      a_we0 = 1'b0; a_we1 = 1'b0;
      a_waddr0 = '0; a_waddr1 = '0;
      a_wdata0 = '0; a_wdata1 = '0;
   endtask

   task automatic a_set_rd(input int p, input logic [A_AW-1:0] addr);
      a_rd_addr[p*A_AW +: A_AW] = addr;
   endtask

   function automatic logic [A_XLEN-1:0] a_rd(input int p);
      return a_rd_data[p*A_XLEN +: A_XLEN];
   endfunction

   function automatic logic [B_XLEN-1:0] b_rd(input int p);
      return b_rd_data[p*B_XLEN +: B_XLEN];
   endfunction

   // Expected read value for instance B from the current inputs and model.
   function automatic logic [B_XLEN-1:0] b_expect(input logic [B_AW-1:0] addr);
      if (addr == 0) return '0;
      if (b_we1 && (b_waddr1 == addr)) return b_wdata1;
      if (b_we0 && (b_waddr0 == addr)) return b_wdata0;
      return mb[addr];
   endfunction

   // ---------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------
   task automatic test_reset();
      int  cnt;
      bit  bad;
      a_idle();
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_set_rd(0, 5'd3); a_set_rd(1, 5'd17);
      repeat (3) step();
      checks++;
      if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", a_busy); end
      checks++;
      if (a_wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b want 0", a_wr_drop); end
      checks++;
      if (a_rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", a_rd_data); end

      a_rst_n = 1'b1; b_rst_n = 1'b1;
      cnt = 0; bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (a_busy !== 1'b1) break;
         cnt++;
         a_set_rd(0, 5'($urandom_range(1, 31)));
         a_set_rd(1, 5'($urandom_range(1, 31)));
         #1;
         if (a_rd_data !== '0) bad = 1'b1;
      end
      checks++;
      if (cnt != 31) begin errors++; $display("FAIL clear_busy_len: got %0d want 31", cnt); end
      checks++;
      if (bad) begin errors++; $display("FAIL clear_rd_zero: got nonzero want 0"); end
      checks++;
      if (a_busy !== 1'b0) begin errors++; $display("FAIL ready_busy: got %b want 0", a_busy); end

      bad = 1'b0;
      for (int r = 0; r < A_DEPTH; r += 2) begin
         a_set_rd(0, 5'(r)); a_set_rd(1, 5'(r + 1));
         #1;
         if (a_rd_data !== '0) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL cleared_array: got nonzero want all 0"); end
   endtask

   task automatic test_bypass();
      a_idle();
      a_set_rd(0, 5'd5); a_set_rd(1, 5'd5);
      a_we0 = 1'b1; a_waddr0 = 5'd5; a_wdata0 = 64'h1234;
      #1;
      checks++;
      if (a_rd(0) !== 64'h1234) begin errors++; $display("FAIL bypass_p0: got %h want 1234", a_rd(0)); end
      checks++;
      if (a_rd(1) !== 64'h1234) begin errors++; $display("FAIL bypass_p1: got %h want 1234", a_rd(1)); end
      step();
      a_idle();
      #1;
      checks++;
      if (a_rd(0) !== 64'h1234) begin errors++; $display("FAIL array_read_x5: got %h want 1234", a_rd(0)); end
      checks++;
      if (a_wr_drop !== 1'b0) begin errors++; $display("FAIL good_write_drop: got %b want 0", a_wr_drop); end
   endtask

   task automatic test_dual_same();
      a_idle();
      a_set_rd(0, 5'd7); a_set_rd(1, 5'd5);
      a_we0 = 1'b1; a_waddr0 = 5'd7; a_wdata0 = 64'hA;
      a_we1 = 1'b1; a_waddr1 = 5'd7; a_wdata1 = 64'hB;
      #1;
      checks++;
      if (a_rd(0) !== 64'hB) begin errors++; $display("FAIL collide_bypass: got %h want b", a_rd(0)); end
      step();
      a_idle();
      #1;
      checks++;
      if (a_wr_drop !== 1'b1) begin errors++; $display("FAIL collide_drop: got %b want 1", a_wr_drop); end
      checks++;
      if (a_rd(0) !== 64'hB) begin errors++; $display("FAIL collide_reg7: got %h want b", a_rd(0)); end
      checks++;
      if (a_rd(1) !== 64'h1234) begin errors++; $display("FAIL collide_reg5: got %h want 1234", a_rd(1)); end
      step();
      checks++;
      if (a_wr_drop !== 1'b0) begin errors++; $display("FAIL drop_pulse: got %b want 0", a_wr_drop); end
   endtask

   task automatic test_x0();
      a_idle();
      a_set_rd(0, 5'd0); a_set_rd(1, 5'd0);
      a_we1 = 1'b1; a_waddr1 = 5'd0; a_wdata1 = 64'hFFFF;
      #1;
      checks++;
      if (a_rd_data !== '0) begin errors++; $display("FAIL x0_bypass: got %h want 0", a_rd_data); end
      step();
      a_idle();
      #1;
      checks++;
      if (a_wr_drop !== 1'b1) begin errors++; $display("FAIL x0_drop: got %b want 1", a_wr_drop); end
      checks++;
      if (a_rd_data !== '0) begin errors++; $display("FAIL x0_read: got %h want 0", a_rd_data); end
   endtask

   task automatic test_reset_mid_clear();
      int cnt;
      a_idle();
      a_we0 = 1'b1; a_waddr0 = 5'd9; a_wdata0 = 64'h55;
      step();
      a_idle();
      a_set_rd(0, 5'd9); a_set_rd(1, 5'd3);
      #1;
      checks++;
      if (a_rd(0) !== 64'h55) begin errors++; $display("FAIL pre_reset_x9: got %h want 55", a_rd(0)); end

      a_rst_n = 1'b0;
      step();
      a_rst_n = 1'b1;
      repeat (10) step();   // clear counter now at 10
      checks++;
      if (a_busy !== 1'b1) begin errors++; $display("FAIL mid_clear_busy: got %b want 1", a_busy); end
      a_rst_n = 1'b0;
      step();
      a_rst_n = 1'b1;

      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (a_busy !== 1'b1) break;
         cnt++;
         if (cnt == 2) begin
            a_we0 = 1'b1; a_waddr0 = 5'd3; a_wdata0 = 64'hDEAD;
         end else if (cnt == 3) begin
            a_idle();
            checks++;
            if (a_wr_drop !== 1'b1) begin errors++; $display("FAIL busy_write_drop: got %b want 1", a_wr_drop); end
         end
      end
      checks++;
      if (cnt != 31) begin errors++; $display("FAIL restart_busy_len: got %0d want 31", cnt); end
      #1;
      checks++;
      if (a_rd(1) !== '0) begin errors++; $display("FAIL busy_write_x3: got %h want 0", a_rd(1)); end
      checks++;
      if (a_rd(0) !== '0) begin errors++; $display("FAIL recleared_x9: got %h want 0", a_rd(0)); end
   endtask

   task automatic test_random();
      logic [B_XLEN-1:0] exp;
      logic              exp_drop;
      logic [B_AW-1:0]   ra;
      checks++;
      if (b_busy !== 1'b0) begin errors++; $display("FAIL b_ready: got busy=%b want 0", b_busy); end
      for (int r = 0; r < B_DEPTH; r++) mb[r] = '0;

      for (int c = 0; c < 1000; c++) begin
         b_we0    = 1'($urandom_range(0, 1));
         b_we1    = 1'($urandom_range(0, 1));
         b_waddr0 = 4'($urandom_range(0, 15));
         b_waddr1 = ($urandom_range(0, 3) == 0) ? b_waddr0 : 4'($urandom_range(0, 15));
         b_wdata0 = $urandom();
         b_wdata1 = $urandom();
         for (int p = 0; p < B_NRD; p++) begin
            case ($urandom_range(0, 3))
               0:       b_rd_addr[p*B_AW +: B_AW] = b_waddr0;
               1:       b_rd_addr[p*B_AW +: B_AW] = b_waddr1;
               default: b_rd_addr[p*B_AW +: B_AW] = 4'($urandom_range(0, 15));
            endcase
         end
         #1;
         for (int p = 0; p < B_NRD; p++) begin
            ra  = b_rd_addr[p*B_AW +: B_AW];
            exp = b_expect(ra);
            checks++;
            if (b_rd(p) !== exp) begin
               errors++;
               $display("FAIL rand_read c=%0d port=%0d addr=%0d: got %h want %h", c, p, ra, b_rd(p), exp);
            end
         end
         exp_drop = (b_we1 && (b_waddr1 == 0)) ||
                    (b_we0 && ((b_waddr0 == 0) || (b_we1 && (b_waddr1 == b_waddr0))));
         step();
         checks++;
         if (b_wr_drop !== exp_drop) begin
            errors++;
            $display("FAIL rand_drop c=%0d: got %b want %b", c, b_wr_drop, exp_drop);
         end
         if (b_we0 && (b_waddr0 != 0) && !(b_we1 && (b_waddr1 == b_waddr0))) mb[b_waddr0] = b_wdata0;
         if (b_we1 && (b_waddr1 != 0)) mb[b_waddr1] = b_wdata1;
      end

      b_we0 = 1'b0; b_we1 = 1'b0;
      for (int r = 0; r < B_DEPTH; r += B_NRD) begin
         for (int p = 0; p < B_NRD; p++) b_rd_addr[p*B_AW +: B_AW] = 4'(r + p);
         #1;
         for (int p = 0; p < B_NRD; p++) begin
            checks++;
            if (b_rd(p) !== mb[r + p]) begin
               errors++;
               $display("FAIL final_sweep x%0d: got %h want %h", r + p, b_rd(p), mb[r + p]);
            end
         end
      end
   endtask

   // ---------------------------------------------------------------------
   // Sequencer and watchdog
   // ---------------------------------------------------------------------
   initial begin
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_rd_addr = '0; b_rd_addr = '0;
      a_idle();
      b_we0 = 1'b0; b_we1 = 1'b0;
      b_waddr0 = '0; b_waddr1 = '0;
      b_wdata0 = '0; b_wdata1 = '0;

      test_reset();
      test_bypass();
      test_dual_same();
      test_x0();
      test_reset_mid_clear();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule : tb_regfile_mp
`default_nettype wire
